// File: rtl/sprite_draw_scheduler.sv
// Per-frame scheduler sharing one VGA plot port among NUM_SPRITES animators.
// Define SPRITE_TIMEOUT_EN to abandon a slot whose done never arrives.
module sprite_draw_scheduler #(
   parameter int NUM_SPRITES    = 4,
   parameter int ID_W           = 2,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     frame_tick,
   input  logic [NUM_SPRITES-1:0]   sprite_en,
   output logic [NUM_SPRITES-1:0]   go,
   input  logic [NUM_SPRITES-1:0]   done,
   input  logic [8*NUM_SPRITES-1:0] pix_x,
   input  logic [7*NUM_SPRITES-1:0] pix_y,
   input  logic [3*NUM_SPRITES-1:0] pix_colour,
   input  logic [NUM_SPRITES-1:0]   pix_we,
   output logic [7:0]               vga_x,
   output logic [6:0]               vga_y,
   output logic [2:0]               vga_colour,
   output logic                     vga_plot,
   output logic                     busy,
   output logic [ID_W-1:0]          active_id,
   output logic                     frame_done,
   output logic                     overrun,
   input  logic                     overrun_clr,
   output logic                     timeout_err
);

   if ((2 ** ID_W) < NUM_SPRITES) begin : g_bad_id_w
      $error("ID_W too narrow for NUM_SPRITES");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ADV} state_t;

   localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_SPRITES - 1);

   state_t                  r_state;
   logic [ID_W-1:0]         r_idx;
   logic                    r_busy;
   logic                    r_frame_done;
   logic                    r_overrun;

   logic                    w_en_sel;
   logic                    w_done_sel;
   logic                    w_we_sel;
   logic [7:0]              w_x_sel;
   logic [6:0]              w_y_sel;
   logic [2:0]              w_colour_sel;
   logic [NUM_SPRITES-1:0]  w_slot_hot;
   logic                    w_in_wait;
   logic                    w_timeout;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_en_sel     = 1'b0;
      w_done_sel   = 1'b0;
      w_we_sel     = 1'b0;
      w_x_sel      = '0;
      w_y_sel      = '0;
      w_colour_sel = '0;
      w_slot_hot   = '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         if (r_idx == ID_W'(i)) begin
            w_en_sel      = sprite_en[i];
            w_done_sel    = done[i];
            w_we_sel      = pix_we[i];
            w_x_sel       = pix_x[8*i +: 8];
            w_y_sel       = pix_y[7*i +: 7];
            w_colour_sel  = pix_colour[3*i +: 3];
            w_slot_hot[i] = 1'b1;
         end
      end
   end

   assign w_in_wait = (r_state == S_WAIT);

`ifdef SPRITE_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] r_wait_cnt;
   logic             r_timeout_err;

   // done arriving in the last allowed cycle still counts as success.
   assign w_timeout   = w_in_wait && !w_done_sel &&
                        (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign timeout_err = r_timeout_err;
`else
   assign w_timeout   = 1'b0;
   assign timeout_err = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_idx        <= '0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_overrun    <= 1'b0;
`ifdef SPRITE_TIMEOUT_EN
         r_wait_cnt    <= '0;
         r_timeout_err <= 1'b0;
`endif
      end else begin
         r_frame_done <= 1'b0;
         if (frame_tick && (r_state != S_IDLE)) begin
            r_overrun <= 1'b1;
         end else if (overrun_clr) begin
            r_overrun <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (frame_tick) begin
                  r_state <= S_ISSUE;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            S_ISSUE: r_state <= w_en_sel ? S_WAIT : S_ADV;
            S_WAIT: begin
               if (w_done_sel || w_timeout) begin
                  r_state <= S_ADV;
               end
            end
            S_ADV: begin
               if (r_idx == LAST_IDX) begin
                  r_state      <= S_IDLE;
                  r_idx        <= '0;
                  r_busy       <= 1'b0;
                  r_frame_done <= 1'b1;
               end else begin
                  r_idx   <= r_idx + 1'b1;
                  r_state <= S_ISSUE;
               end
            end
            default: r_state <= S_IDLE;
         endcase

`ifdef SPRITE_TIMEOUT_EN
         r_wait_cnt <= w_in_wait ? r_wait_cnt + 1'b1 : '0;
         if (w_timeout) begin
            r_timeout_err <= 1'b1;
         end
`endif
      end
   end

   // go is decoded from state so it lands in the ISSUE cycle itself; reset masks it.
   assign go         = (r_state == S_ISSUE && w_en_sel && !reset) ? w_slot_hot : '0;
   assign vga_x      = w_in_wait ? w_x_sel : '0;
   assign vga_y      = w_in_wait ? w_y_sel : '0;
   assign vga_colour = w_in_wait ? w_colour_sel : '0;
   assign vga_plot   = w_in_wait && w_we_sel && !w_timeout;
   assign busy       = r_busy;
   assign active_id  = r_idx;
   assign frame_done = r_frame_done;
   assign overrun    = r_overrun;

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Self-checking bench for sprite_draw_scheduler: each frame walk is turned into an
// expected per-cycle timeline from the slot-cost rules, then compared cycle by cycle.
module tb_sprite_draw_scheduler;

   localparam int NS   = 4;
   localparam int IDW  = 2;
   localparam int TO   = 16;
   localparam int MAXC = 256;
`ifdef SPRITE_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic            frame_tick;
   logic [NS-1:0]   sprite_en;
   logic [NS-1:0]   go;
   logic [NS-1:0]   done;
   logic [8*NS-1:0] pix_x;
   logic [7*NS-1:0] pix_y;
   logic [3*NS-1:0] pix_colour;
   logic [NS-1:0]   pix_we;
   logic [7:0]      vga_x;
   logic [6:0]      vga_y;
   logic [2:0]      vga_colour;
   logic            vga_plot;
   logic            busy;
   logic [IDW-1:0]  active_id;
   logic            frame_done;
   logic            overrun;
   logic            overrun_clr;
   logic            timeout_err;

   sprite_draw_scheduler #(.NUM_SPRITES(NS), .ID_W(IDW), .TIMEOUT_CYCLES(TO)) dut (
      .clock(clk), .reset(rst), .frame_tick(frame_tick), .sprite_en(sprite_en),
      .go(go), .done(done), .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour),
      .pix_we(pix_we), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
      .vga_plot(vga_plot), .busy(busy), .active_id(active_id), .frame_done(frame_done),
      .overrun(overrun), .overrun_clr(overrun_clr), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // frame description
   logic [NS-1:0] f_en;
   int            f_lat[NS];      // WAIT cycles until done; 0 = never
   bit            f_fixed_pix;
   int            f_abort;
   bit            f_tick_x[MAXC];
   bit            f_clr[MAXC];

   // expected timeline
   logic [NS-1:0] e_go[MAXC];
   int            e_wslot[MAXC];
   bit            e_dhit[MAXC];
   bit            e_to[MAXC];
   bit            e_busy[MAXC];
   bit            e_fd[MAXC];
   int            e_act[MAXC];
   int            e_n;

   bit            m_ovr;
   bit            m_terr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_frame();
      f_fixed_pix = 1'b0;
      f_abort     = -1;
      for (int c = 0; c < MAXC; c++) begin
         f_tick_x[c] = 1'b0;
         f_clr[c]    = 1'b0;
      end
   endtask

   // Slot costs: enabled = ISSUE + WAIT(lat, or TO on timeout) + ADV, disabled = ISSUE + ADV.
   task automatic build();
      int k;
      int wl;
      bit timed;
      logic [NS-1:0] one;
      one = 1;
      for (int c = 0; c < MAXC; c++) begin
         e_go[c] = '0; e_wslot[c] = -1; e_dhit[c] = 0; e_to[c] = 0;
         e_busy[c] = 0; e_fd[c] = 0; e_act[c] = 0;
      end
      k = 1;
      for (int i = 0; i < NS; i++) begin
         e_busy[k] = 1; e_act[k] = i;
         if (f_en[i]) e_go[k] = one << i;
         k++;
         if (f_en[i]) begin
            timed = (f_lat[i] == 0) || (TO_EN && f_lat[i] > TO);
            wl    = timed ? TO : f_lat[i];
            for (int j = 1; j <= wl; j++) begin
               e_busy[k] = 1; e_act[k] = i; e_wslot[k] = i;
               e_dhit[k] = !timed && (j == wl);
               e_to[k]   = timed && (j == wl);
               k++;
            end
         end
         e_busy[k] = 1; e_act[k] = i;
         k++;
      end
      e_fd[k] = 1;
      e_n     = k;
   endtask

   task automatic drive_random(input bit tick, input bit clr);
      frame_tick  = tick;
      overrun_clr = clr;
      done        = NS'($urandom);
      pix_x       = $urandom;
      pix_y       = 28'($urandom);
      pix_colour  = 12'($urandom);
      pix_we      = NS'($urandom);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, " busy"}, 32'(busy), 0);
      check({tag, " go"}, 32'(go), 0);
      check({tag, " plot"}, 32'(vga_plot), 0);
      check({tag, " vga_x"}, 32'(vga_x), 0);
      check({tag, " active_id"}, 32'(active_id), 0);
      check({tag, " frame_done"}, 32'(frame_done), 0);
      check({tag, " overrun"}, 32'(overrun), 32'(m_ovr));
      check({tag, " timeout_err"}, 32'(timeout_err), 32'(m_terr));
   endtask

   task automatic idle(input bit clr);
      @(posedge clk); #1;
      drive_random(1'b0, clr);
      @(negedge clk);
      check_quiet("idle");
      if (clr) m_ovr = 1'b0;
   endtask

   task automatic run_frame(input string name);
      int  s;
      logic [7:0] ex;
      logic [6:0] ey;
      logic [2:0] ec;
      bit  ep;
      for (int k = 0; k <= e_n; k++) begin
         @(posedge clk); #1;
         drive_random((k == 0) || f_tick_x[k], f_clr[k]);
         sprite_en = f_en;
         if (e_wslot[k] >= 0) done[e_wslot[k]] = e_dhit[k];
         if (f_fixed_pix) begin
            pix_x[23:16] = 8'h4C; pix_y[20:14] = 7'h3A; pix_colour[8:6] = 3'b110;
            pix_we[2] = 1'b1; pix_we[0] = 1'b1;
         end
         if (k == f_abort) begin
            rst = 1'b1;
            @(negedge clk);
            check($sformatf("%s reset-cycle go", name), 32'(go), 0);
            @(posedge clk); #1;
            rst = 1'b0;
            drive_random(1'b0, 1'b0);
            m_ovr = 1'b0; m_terr = 1'b0;
            @(negedge clk);
            check_quiet($sformatf("%s post-reset", name));
            break;
         end
         @(negedge clk);
         s  = e_wslot[k];
         ex = (s >= 0) ? pix_x[8*s +: 8] : 8'h0;
         ey = (s >= 0) ? pix_y[7*s +: 7] : 7'h0;
         ec = (s >= 0) ? pix_colour[3*s +: 3] : 3'h0;
         ep = (s >= 0) ? (pix_we[s] && !e_to[k]) : 1'b0;
         check($sformatf("%s c%0d go", name, k), 32'(go), 32'(e_go[k]));
         check($sformatf("%s c%0d active_id", name, k), 32'(active_id), 32'(e_act[k]));
         check($sformatf("%s c%0d busy", name, k), 32'(busy), 32'(e_busy[k]));
         check($sformatf("%s c%0d frame_done", name, k), 32'(frame_done), 32'(e_fd[k]));
         check($sformatf("%s c%0d vga_x", name, k), 32'(vga_x), 32'(ex));
         check($sformatf("%s c%0d vga_y", name, k), 32'(vga_y), 32'(ey));
         check($sformatf("%s c%0d vga_colour", name, k), 32'(vga_colour), 32'(ec));
         check($sformatf("%s c%0d vga_plot", name, k), 32'(vga_plot), 32'(ep));
         check($sformatf("%s c%0d overrun", name, k), 32'(overrun), 32'(m_ovr));
         check($sformatf("%s c%0d timeout_err", name, k), 32'(timeout_err), 32'(m_terr));
         if (frame_tick && e_busy[k]) m_ovr = 1'b1;
         else if (overrun_clr) m_ovr = 1'b0;
         if (e_to[k]) m_terr = 1'b1;
      end
      clear_frame();
   endtask

   initial begin
      rst = 1'b1;
      frame_tick = 1'b0; overrun_clr = 1'b0; sprite_en = '0; done = '0;
      pix_x = '0; pix_y = '0; pix_colour = '0; pix_we = '0;
      m_ovr = 1'b0; m_terr = 1'b0;
      clear_frame();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_quiet("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (7) idle(1'b0);

      // all enabled, done 5 cycles after each go
      f_en = 4'hF;
      for (int i = 0; i < NS; i++) f_lat[i] = 5;
      build(); run_frame("all5");
      idle(1'b0);

      // slot 2 carries fixed pixel data while pix_we[0] is also high
      for (int i = 0; i < NS; i++) f_lat[i] = 2 + i;
      f_fixed_pix = 1'b1;
      build(); run_frame("pix");

      // sparse enables, done already high on the first WAIT cycle of slot 0
      f_en = 4'b0101; f_lat[0] = 1; f_lat[2] = 4;
      build(); run_frame("en0101");

      // mid-walk tick sets overrun, then clear it from idle
      f_en = 4'hF;
      for (int i = 0; i < NS; i++) f_lat[i] = 3;
      build(); f_tick_x[10] = 1'b1; run_frame("ovr");
      idle(1'b0); idle(1'b1); idle(1'b0);

      // set wins over clear; tick on the final ADV cycle is dropped
      build(); f_tick_x[6] = 1'b1; f_clr[6] = 1'b1; run_frame("setwins");
      idle(1'b1);
      build(); f_tick_x[e_n - 1] = 1'b1; run_frame("advtick");
      idle(1'b1); idle(1'b0);

      // reset during slot 1 WAIT, then during slot 1 ISSUE, each followed by a clean walk
      for (int i = 0; i < NS; i++) f_lat[i] = 5;
      build(); f_abort = 10; run_frame("abort_wait");
      idle(1'b0);
      build(); run_frame("after_abort");
      build(); f_abort = 8; run_frame("abort_issue");
      idle(1'b0);
      build(); run_frame("after_abort2");

      if (TO_EN) begin
         f_en = 4'hF; f_lat[0] = 2; f_lat[1] = TO; f_lat[2] = 1; f_lat[3] = 1;
         build(); run_frame("done_at_limit");
         f_lat[1] = 0; f_lat[2] = 3;
         build(); run_frame("timeout");
         idle(1'b0);
      end

      for (int r = 0; r < 20; r++) begin
         f_en = NS'($urandom);
         for (int i = 0; i < NS; i++) begin
            f_lat[i] = $urandom_range(1, 6);
            if (TO_EN && ($urandom_range(0, 7) == 0)) f_lat[i] = 0;
         end
         build();
         for (int c = 1; c < e_n; c++) f_tick_x[c] = ($urandom_range(0, 7) == 0);
         for (int c = 0; c <= e_n; c++) f_clr[c] = ($urandom_range(0, 7) == 0);
         run_frame($sformatf("rnd%0d", r));
         idle($urandom_range(0, 1) == 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
